instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter PC_W, default 8: program-counter width in 16-bit-word addresses, giving a 256-word instruction space.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 stall  input  1  1 = hold PC and decode outputs this cycle.
REQ-005 branch_taken  input  1  1 = redirect fetch to branch_target (driven by the downstream branch logic).
REQ-006 branch_target  input  PC_W  redirect word address.
REQ-007 imem_addr  output  PC_W  instruction-memory read address; memory has synchronous read, 1-cycle latency.
REQ-008 imem_rdata  input  16  instruction word returned for the address presented the previous cycle.
REQ-009 opcode  output  4  instruction bits [15:12]; feeds the controller OPCode input.
REQ-010 rs, rt, rd  output  3 each  register fields from bits [11:9], [8:6] and [5:3].
REQ-011 funct  output  3  bits [2:0].
REQ-012 imm6  output  6  bits [5:0], zero-extended by downstream logic.
REQ-013 pc_out  output  PC_W  address of the instruction currently on the decode outputs.
REQ-014 valid  output  1  1 = decode outputs hold a real instruction.
REQ-015 halted  output  1  1 = HALT state reached.

Function
REQ-016 Three-state FSM: FILL, RUN, HALT.
REQ-017 FILL is entered on reset, lasts exactly one cycle, and advances unconditionally to RUN.
REQ-018 Internal pc register holds the address of the instruction being output.
REQ-019 pc_next has the following priority: HALT or stall -> pc; branch_taken -> branch_target; otherwise -> pc+1.
REQ-020 pc+1 wraps modulo 2^PC_W; 8'hFF increments to 8'h00.
REQ-021 imem_addr SHALL equal pc_next combinationally, so imem_rdata in cycle N+1 always corresponds to pc in cycle N+1.
REQ-022 In FILL, pc_next is 0 and imem_addr is 0; pc remains 0.
REQ-023 valid = 1 only in RUN; valid = 0 in FILL and HALT.
REQ-024 When valid = 0, opcode is forced to OP_NOP (4'b1110) and rs, rt, rd, funct and imm6 are forced to 0.
REQ-025 When valid = 1, all decode fields pass imem_rdata through combinationally with no added latency.
REQ-026 Stall keeps pc and imem_addr unchanged, so the memory re-reads the same word and the outputs stay stable.
REQ-027 branch_taken is ignored while stall = 1.
REQ-028 A taken branch takes effect next cycle: pc = branch_target, and the target instruction appears with valid = 1.
REQ-029 There is no delay slot and no bubble.
REQ-030 RUN -> HALT when valid = 1, opcode = OP_HALT (4'b1111) and stall = 0.
REQ-031 When stall = 1, the RUN -> HALT transition is deferred until stall drops.
REQ-032 In HALT, pc freezes at the HALT instruction's address, halted = 1, and branch_taken and stall are ignored.
REQ-033 HALT is exited only by reset.
REQ-034 If branch_taken and the OP_HALT condition occur in the same cycle, HALT wins and no redirect occurs.

Reset
REQ-035 rst_n low asynchronously sets: state = FILL, pc = 0, valid = 0, halted = 0, opcode = OP_NOP, pc_out = 0.
REQ-036 rst_n asserted mid-stall, mid-branch or in HALT discards all in-flight state.
REQ-037 After rst_n deasserts, the first valid instruction is word 0, presented on the second rising edge.

Structure
REQ-038 A shared package mini_mips_pkg holds: OP_NOP, OP_HALT, instruction field bit positions, and the FILL/RUN/HALT state encoding.
REQ-039 The controller opcode constants also reside in mini_mips_pkg.
REQ-040 One sub-module, pc_reg, is permitted: the PC register with async reset, hold enable and load mux.
REQ-041 The instruction memory is external and SHALL NOT be instantiated inside instr_fetch.

Verification
REQ-042 Reset then free-run, memory word k = {4'(k%10), 12'h000} -> valid rises on the 2nd edge; opcode sequence 0,1,2,...; pc_out 0,1,2,....
REQ-043 stall held high 3 cycles at pc = 5 -> pc_out = 5, opcode unchanged, imem_addr = 5 throughout; pc = 6 on the first cycle after release.
REQ-044 branch_taken with branch_target = 8'h40 at pc = 3 -> next cycle pc_out = 8'h40, valid = 1; stall asserted concurrently -> no redirect.
REQ-045 Word 7 = 16'hF000 -> halted = 1 and valid = 0 one cycle later, pc_out stays 7; later branch_taken and stall have no effect.
REQ-046 pc at 8'hFF, no branch -> next pc_out = 8'h00; rst_n pulsed low mid-run -> outputs immediately equal reset values and restart from word 0.

Source files
------------

// File: rtl/mini_mips_pkg.sv
// Shared mini-MIPS definitions: controller opcodes, instruction field layout,
// fetch FSM encoding and small decode helpers.
package mini_mips_pkg;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0001;
    localparam logic [3:0] OP_ANDI  = 4'b0010;
    localparam logic [3:0] OP_ORI   = 4'b0011;
    localparam logic [3:0] OP_LW    = 4'b0100;
    localparam logic [3:0] OP_SW    = 4'b0101;
    localparam logic [3:0] OP_BEQ   = 4'b0110;
    localparam logic [3:0] OP_BNE   = 4'b0111;
    localparam logic [3:0] OP_J     = 4'b1000;
    localparam logic [3:0] OP_JAL   = 4'b1001;
    localparam logic [3:0] OP_LUI   = 4'b1010;
    localparam logic [3:0] OP_SLTI  = 4'b1011;
    localparam logic [3:0] OP_XORI  = 4'b1100;
    localparam logic [3:0] OP_JR    = 4'b1101;
    localparam logic [3:0] OP_NOP   = 4'b1110;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    localparam int INSTR_W   = 16;
    localparam int OPC_MSB   = 15;
    localparam int OPC_LSB   = 12;
    localparam int RS_MSB    = 11;
    localparam int RS_LSB    = 9;
    localparam int RT_MSB    = 8;
    localparam int RT_LSB    = 6;
    localparam int RD_MSB    = 5;
    localparam int RD_LSB    = 3;
    localparam int FUNCT_MSB = 2;
    localparam int FUNCT_LSB = 0;
    localparam int IMM6_MSB  = 5;
    localparam int IMM6_LSB  = 0;

    localparam logic [1:0] ST_FILL = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_HALT = 2'b10;

    typedef logic [INSTR_W-1:0] instr_t;

    typedef struct packed {
        logic [3:0] opcode;
        logic [2:0] rs;
        logic [2:0] rt;
        logic [2:0] rd;
        logic [2:0] funct;
        logic [5:0] imm6;
    } decode_t;

    // imm6 deliberately overlaps rd/funct; downstream picks whichever it needs.
    function automatic decode_t decode_instr(input instr_t w);
        decode_t d;
        d.opcode = w[OPC_MSB:OPC_LSB];
        d.rs     = w[RS_MSB:RS_LSB];
        d.rt     = w[RT_MSB:RT_LSB];
        d.rd     = w[RD_MSB:RD_LSB];
        d.funct  = w[FUNCT_MSB:FUNCT_LSB];
        d.imm6   = w[IMM6_MSB:IMM6_LSB];
        return d;
    endfunction

    function automatic decode_t nop_decode();
        decode_t d;
        d        = '0;
        d.opcode = OP_NOP;
        return d;
    endfunction

    function automatic logic is_halt_op(input logic [3:0] op);
        return op == OP_HALT;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: redirect/stall controls, instruction-memory port and
// decoded instruction fields. master = fetch unit, slave = its surroundings.
interface instr_fetch_if #(
    parameter int PC_W = 8
);
    logic            stall;
    logic            branch_taken;
    logic [PC_W-1:0] branch_target;
    logic [PC_W-1:0] imem_addr;
    logic [15:0]     imem_rdata;
    logic [3:0]      opcode;
    logic [2:0]      rs;
    logic [2:0]      rt;
    logic [2:0]      rd;
    logic [2:0]      funct;
    logic [5:0]      imm6;
    logic [PC_W-1:0] pc_out;
    logic            valid;
    logic            halted;

    modport master (
        input  stall, branch_taken, branch_target, imem_rdata,
        output imem_addr, opcode, rs, rt, rd, funct, imm6, pc_out, valid, halted
    );

    modport slave (
        output stall, branch_taken, branch_target, imem_rdata,
        input  imem_addr, opcode, rs, rt, rd, funct, imm6, pc_out, valid, halted
    );
endinterface

// File: rtl/pc_reg.sv
// Program counter with hold and load: next value is hold ? pc : load ? load_val : pc+1,
// exported combinationally so it can address a synchronous-read memory.
module pc_reg #(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            hold,
    input  logic            load,
    input  logic [PC_W-1:0] load_val,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_next
);
    logic [PC_W-1:0] cur_pc_reg;

    // Increment wraps naturally modulo 2^PC_W.
    always_comb begin
        pc_next = cur_pc_reg + PC_W'(1);
        if (hold) begin
            pc_next = cur_pc_reg;
        end else if (load) begin
            pc_next = load_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_pc_reg <= '0;
        end else begin
            cur_pc_reg <= pc_next;
        end
    end

    assign pc = cur_pc_reg;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch/decode front end: FILL -> RUN -> HALT sequencer, PC steering
// and field decode of the word returned by an external 1-cycle-latency memory.
module instr_fetch
    import mini_mips_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus
);
    logic [1:0]      state_reg;
    logic [1:0]      state_next;
    logic            in_run;
    logic            in_halt;
    logic            halt_now;
    logic            pc_hold;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_next;
    decode_t         dec_raw;
    decode_t         dec_out;

    assign in_run  = (state_reg == ST_RUN);
    assign in_halt = (state_reg == ST_HALT);

    assign dec_raw  = decode_instr(bus.imem_rdata);
    assign halt_now = in_run && is_halt_op(dec_raw.opcode) && !bus.stall;

    // FILL only ever follows reset, so holding there keeps pc and imem_addr at 0.
    // Holding on halt_now makes HALT beat a same-cycle branch.
    assign pc_hold = !in_run || bus.stall || halt_now;

    pc_reg #(
        .PC_W (PC_W)
    ) u_pc_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .hold     (pc_hold),
        .load     (bus.branch_taken),
        .load_val (bus.branch_target),
        .pc       (pc),
        .pc_next  (pc_next)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_FILL: state_next = ST_RUN;
            ST_RUN:  state_next = halt_now ? ST_HALT : ST_RUN;
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_FILL;
        end else begin
            state_reg <= state_next;
        end
    end

    assign dec_out = in_run ? dec_raw : nop_decode();

    assign bus.imem_addr = pc_next;
    assign bus.opcode    = dec_out.opcode;
    assign bus.rs        = dec_out.rs;
    assign bus.rt        = dec_out.rt;
    assign bus.rd        = dec_out.rd;
    assign bus.funct     = dec_out.funct;
    assign bus.imm6      = dec_out.imm6;
    assign bus.pc_out    = pc;
    assign bus.valid     = in_run;
    assign bus.halted    = in_halt;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed table-driven bench for instr_fetch with a behavioural synchronous-read memory.
module tb_instr_fetch;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    instr_fetch_if #(.PC_W(8)) bus ();

    instr_fetch #(.PC_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [15:0] mem [256];

    always @(posedge clk) bus.imem_rdata <= mem[bus.imem_addr];

    typedef struct {
        logic        stall;
        logic        bt;
        logic [7:0]  tgt;
        logic        e_valid;
        logic        e_halted;
        logic [7:0]  e_pc;
        logic [7:0]  e_addr;
        logic [15:0] e_word;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   passed = 0;
    int   row_id = -1;
    int   a_end, b_end, c_end;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s row %0d: got %0h, expected %0h", name, row_id, act, exp);
    endtask

    task automatic add(input logic s, input logic b, input logic [7:0] t,
                       input logic v, input logic h, input logic [7:0] p,
                       input logic [7:0] a, input logic [15:0] w);
        vec_t r;
        r.stall = s; r.bt = b; r.tgt = t;
        r.e_valid = v; r.e_halted = h; r.e_pc = p; r.e_addr = a; r.e_word = w;
        vecs.push_back(r);
    endtask

    // Word k holds opcode k%10 in its top nibble; one extra word is patched per phase.
    task automatic load_mem(input bit with_halt);
        for (int k = 0; k < 256; k++) mem[k] = {4'(k % 10), 12'h000};
        if (with_halt) mem[7] = 16'hF000;
        else           mem[8'h40] = 16'h429C;
    endtask

    task automatic zero_inputs();
        bus.stall = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_target = 8'h00;
    endtask

    task automatic check_reset_vals();
        #1;
        row_id = -1;
        check("rst_valid",  32'(bus.valid),     32'd0);
        check("rst_halted", 32'(bus.halted),    32'd0);
        check("rst_opcode", 32'(bus.opcode),    32'hE);
        check("rst_pc_out", 32'(bus.pc_out),    32'd0);
        check("rst_addr",   32'(bus.imem_addr), 32'd0);
        check("rst_fields", 32'({bus.rs, bus.rt, bus.rd, bus.funct, bus.imm6}), 32'd0);
    endtask

    // Entered on a negedge; each row is applied there and sampled 1 time unit later.
    task automatic run_rows(input int first, input int last);
        for (int i = first; i < last; i++) begin
            row_id = i;
            bus.stall = vecs[i].stall;
            bus.branch_taken = vecs[i].bt;
            bus.branch_target = vecs[i].tgt;
            #1;
            check("valid",     32'(bus.valid),     32'(vecs[i].e_valid));
            check("halted",    32'(bus.halted),    32'(vecs[i].e_halted));
            check("pc_out",    32'(bus.pc_out),    32'(vecs[i].e_pc));
            check("imem_addr", 32'(bus.imem_addr), 32'(vecs[i].e_addr));
            check("opcode",    32'(bus.opcode),    32'(vecs[i].e_word[15:12]));
            check("fields",    32'({bus.rs, bus.rt, bus.rd, bus.funct}), 32'(vecs[i].e_word[11:0]));
            check("imm6",      32'(bus.imm6),      32'(vecs[i].e_word[5:0]));
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Phase A: fill, free run, stall vs branch, redirect, 3-cycle stall, wrap.
        add(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 16'hE000);
        add(0, 0, 8'h00, 1, 0, 8'h00, 8'h01, 16'h0000);
        add(0, 0, 8'h00, 1, 0, 8'h01, 8'h02, 16'h1000);
        add(0, 0, 8'h00, 1, 0, 8'h02, 8'h03, 16'h2000);
        add(1, 1, 8'h40, 1, 0, 8'h03, 8'h03, 16'h3000);
        add(0, 1, 8'h40, 1, 0, 8'h03, 8'h40, 16'h3000);
        add(0, 0, 8'h00, 1, 0, 8'h40, 8'h41, 16'h429C);
        add(0, 1, 8'h05, 1, 0, 8'h41, 8'h05, 16'h5000);
        add(1, 0, 8'h00, 1, 0, 8'h05, 8'h05, 16'h5000);
        add(1, 1, 8'h22, 1, 0, 8'h05, 8'h05, 16'h5000);
        add(1, 0, 8'h00, 1, 0, 8'h05, 8'h05, 16'h5000);
        add(0, 0, 8'h00, 1, 0, 8'h05, 8'h06, 16'h5000);
        add(0, 0, 8'h00, 1, 0, 8'h06, 8'h07, 16'h6000);
        add(0, 1, 8'hFE, 1, 0, 8'h07, 8'hFE, 16'h7000);
        add(0, 0, 8'h00, 1, 0, 8'hFE, 8'hFF, 16'h4000);
        add(0, 0, 8'h00, 1, 0, 8'hFF, 8'h00, 16'h5000);
        add(0, 0, 8'h00, 1, 0, 8'h00, 8'h01, 16'h0000);
        add(0, 0, 8'h00, 1, 0, 8'h01, 8'h02, 16'h1000);
        a_end = vecs.size();

        // Phase B: branch ignored in FILL, run to HALT at word 7 with a same-cycle branch.
        add(0, 1, 8'h30, 0, 0, 8'h00, 8'h00, 16'hE000);
        add(0, 0, 8'h00, 1, 0, 8'h00, 8'h01, 16'h0000);
        add(0, 0, 8'h00, 1, 0, 8'h01, 8'h02, 16'h1000);
        add(0, 0, 8'h00, 1, 0, 8'h02, 8'h03, 16'h2000);
        add(0, 0, 8'h00, 1, 0, 8'h03, 8'h04, 16'h3000);
        add(0, 0, 8'h00, 1, 0, 8'h04, 8'h05, 16'h4000);
        add(0, 0, 8'h00, 1, 0, 8'h05, 8'h06, 16'h5000);
        add(0, 0, 8'h00, 1, 0, 8'h06, 8'h07, 16'h6000);
        add(0, 1, 8'h20, 1, 0, 8'h07, 8'h07, 16'hF000);
        add(1, 1, 8'h20, 0, 1, 8'h07, 8'h07, 16'hE000);
        add(0, 1, 8'h33, 0, 1, 8'h07, 8'h07, 16'hE000);
        add(0, 0, 8'h00, 0, 1, 8'h07, 8'h07, 16'hE000);
        b_end = vecs.size();

        // Phase C: stall in FILL, then HALT deferred while stall is high.
        add(1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 16'hE000);
        add(0, 1, 8'h06, 1, 0, 8'h00, 8'h06, 16'h0000);
        add(0, 0, 8'h00, 1, 0, 8'h06, 8'h07, 16'h6000);
        add(1, 0, 8'h00, 1, 0, 8'h07, 8'h07, 16'hF000);
        add(1, 1, 8'h20, 1, 0, 8'h07, 8'h07, 16'hF000);
        add(0, 0, 8'h00, 1, 0, 8'h07, 8'h07, 16'hF000);
        add(0, 1, 8'h20, 0, 1, 8'h07, 8'h07, 16'hE000);
        add(0, 0, 8'h00, 0, 1, 8'h07, 8'h07, 16'hE000);
        c_end = vecs.size();

        rst_n = 1'b0;
        zero_inputs();
        load_mem(1'b0);
        repeat (2) @(negedge clk);
        check_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;
        run_rows(0, a_end);

        // Asynchronous reset mid-run (pc was 2): outputs must drop at once.
        zero_inputs();
        #2 rst_n = 1'b0;
        check_reset_vals();
        load_mem(1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_rows(a_end, b_end);

        // Reset out of HALT.
        zero_inputs();
        #2 rst_n = 1'b0;
        check_reset_vals();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_rows(b_end, c_end);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
